mul_issue_ctrl: RTL and testbench
=================================

# mul_issue_ctrl

Issue/collect controller placed directly upstream of the 32-bit signed two-stage multiplier (`mul_top`), which it instantiates. It accepts multiply requests from the execute stage through a valid/ready handshake and drives the multiplier operands on the accepting cycle. It tracks the one in-flight operation through the non-stallable multiplier pipeline and captures the 64-bit product into a 2-entry output FIFO. The selected 32-bit half is then presented to writeback with its destination tag under valid/ready backpressure.

## Interface
- `TAG_W`, default 5: width of the destination-register tag.
- `mul_clk` in 1: clock; also drives the `mul_top` instance.
- `resetn` in 1: asynchronous, active-low reset; also drives the `mul_top` instance.
- `flush` in 1: synchronous pipeline flush; discards all held and in-flight work.
- `in_valid` in 1: request valid.
- `in_ready` out 1: controller can accept the request this cycle.
- `in_op` in 1: 0 = MUL (low word), 1 = MULH (high word, signed).
- `in_src1` in 32: signed multiplicand.
- `in_src2` in 32: signed multiplier.
- `in_tag` in TAG_W: destination tag.
- `out_valid` out 1: FIFO head holds a completed result.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out 32: selected half of the product.
- `out_tag` out TAG_W: tag of the head entry.

## Operation
- Handshakes:
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready`.
- Operand drive: `mul_top.src1/src2` are driven with `in_src1/in_src2` when `in_fire`, otherwise with 0. The `mul_top` pipeline cannot stall.
- In-flight register:
  - `inflight` is set to `in_fire` on every edge.
  - `fl_op` and `fl_tag` capture `in_op` and `in_tag` on `in_fire`.
  - In the cycle after `inflight` is set, `mul_top.result` holds that operation's 64-bit product.
- Capture: when `inflight` is 1, the controller pushes {`fl_op ? result[63:32] : result[31:0]`, `fl_tag`} into the FIFO at that cycle's edge. Half selection happens at capture time.
- FIFO:
  - 2 entries, write/read pointers of 1 bit each, `cnt` in 0..2.
  - Head-only read: `out_valid = (cnt != 0)`.
  - `out_data` and `out_tag` come from the head entry.
  - `cnt_next = cnt + inflight - out_fire`. Push and pop in the same cycle are allowed.
- Ready rule: `in_ready = !flush & ((cnt + inflight - out_fire) <= 1)`.
  - This guarantees FIFO space for every accepted op when its product arrives.
  - `in_ready` depends combinationally on `out_ready`.
- Flush:
  - At the edge: `cnt <= 0`, pointers <= 0, `inflight <= 0`.
  - Any product arriving in that cycle or the following cycle from pre-flush work is discarded.
  - `in_ready` is 0 during the flush cycle.
  - `out_fire` in the flush cycle still counts as consumed by the consumer.
- Arithmetic: the full two's-complement signed 32x32 -> 64 product comes from `mul_top`. This block performs no width extension or rounding.

## Timing
- Reset state (async, immediate):
  - `inflight = 0`, `cnt = 0`, pointers = 0.
  - `out_valid = 0`, `out_data = 0`, `out_tag = 0`, `in_ready = 1` (when `flush` = 0).
  - `mul_top` stage 2 cleared.
- Latency: a request accepted at edge N shows `out_valid = 1` with its data after edge N+1, i.e. a 2-cycle accept-to-valid.
- Throughput: 1 op/cycle sustained while `out_ready = 1`.
- Full: with `cnt = 2`, or `cnt = 1` and `inflight = 1`, and no `out_fire`, `in_ready = 0`.
- Order: results leave in strict acceptance order.
- Reset asserted mid-operation: in-flight and buffered results are lost. No spurious `out_valid` appears after deassertion.

## Test plan
- Single MUL: -3 × 5 (0xFFFFFFFD, 0x00000005), tag 7 -> 2 cycles later `out_data` = 0xFFFFFFF1, `out_tag` = 7. The same operands with MULH give 0xFFFFFFFF.
- Corner operands:
  - 0x80000000 × 0x80000000, MULH -> 0x40000000; MUL -> 0x00000000.
  - 0x7FFFFFFF × 0x7FFFFFFF, MULH -> 0x3FFFFFFF; MUL -> 0x00000001.
- Back-to-back: 8 consecutive requests with `out_ready` held at 1 -> `in_ready` stays 1, one result per cycle, order and tags preserved.
- Backpressure: `out_ready` = 0 while issuing 4 requests -> exactly 2 accepted and `in_ready` = 0 thereafter. Raising `out_ready` drains both results in order and `in_ready` recovers in the same cycle as the first pop.
- Flush: issue 2 requests, assert `flush` on the cycle after the second -> no `out_valid` for those requests. A request issued on the cycle after flush returns correctly 2 cycles later.
- Async reset: assert `resetn` = 0 mid-stream between clock edges -> all outputs take reset values immediately. After release, a fresh 6 × 7 MUL yields 42 with correct latency.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// Issue/collect controller around the two-stage signed multiplier: accepts requests,
// tracks the single in-flight op and buffers selected product halves in a 2-entry FIFO.

module mul_top (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [63:0] result
);
    logic signed [63:0] prod_s1;
    logic        [63:0] result_q;

    // Stage 1 multiplies combinationally; stage 2 registers the product.
    assign prod_s1 = 64'($signed(src1)) * 64'($signed(src2));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) result_q <= '0;
        else         result_q <= prod_s1;
    end

    assign result = result_q;
endmodule

module mul_issue_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             mul_clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);
    logic             in_fire, out_fire, push;
    logic [31:0]      mul_a, mul_b;
    logic [63:0]      product;
    logic [31:0]      half_sel;

    logic             inflight_q;
    logic             fl_op_q;
    logic [TAG_W-1:0] fl_tag_q;
    logic [31:0]      data_q [2];
    logic [TAG_W-1:0] tag_q  [2];
    logic             wptr_q, rptr_q;
    logic [1:0]       cnt_q, cnt_d;
    logic [2:0]       occ_after;

    assign out_valid = (cnt_q != 2'd0);
    assign out_fire  = out_valid & out_ready;
    assign out_data  = data_q[rptr_q];
    assign out_tag   = tag_q[rptr_q];

    // Occupancy after this edge counting the in-flight op; at most 1 leaves room for a new accept.
    assign occ_after = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, out_fire};
    assign in_ready  = !flush && (occ_after <= 3'd1);
    assign in_fire   = in_valid & in_ready;

    assign mul_a = in_fire ? in_src1 : 32'd0;
    assign mul_b = in_fire ? in_src2 : 32'd0;

    mul_top u_mul (
        .clk    (mul_clk),
        .resetn (resetn),
        .src1   (mul_a),
        .src2   (mul_b),
        .result (product)
    );

    assign half_sel = fl_op_q ? product[63:32] : product[31:0];
    assign push     = inflight_q & !flush;

    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, out_fire};
        if (flush) cnt_d = 2'd0;
    end

    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            inflight_q <= 1'b0;
            fl_op_q    <= 1'b0;
            fl_tag_q   <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            cnt_q      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            inflight_q <= in_fire;
            cnt_q      <= cnt_d;
            if (in_fire) begin
                fl_op_q  <= in_op;
                fl_tag_q <= in_tag;
            end
            if (flush) begin
                wptr_q <= 1'b0;
                rptr_q <= 1'b0;
            end else begin
                if (push) begin
                    data_q[wptr_q] <= half_sel;
                    tag_q[wptr_q]  <= fl_tag_q;
                    wptr_q         <= ~wptr_q;
                end
                if (out_fire) rptr_q <= ~rptr_q;
            end
        end
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed table, hand sequences and random
// traffic compared against a queue-based reference model.

module tb_mul_issue_ctrl;
    localparam int TAG_W = 5;

    logic             mul_clk = 1'b0;
    logic             resetn, flush, in_valid, in_ready, in_op, out_valid, out_ready;
    logic [31:0]      in_src1, in_src2, out_data;
    logic [TAG_W-1:0] in_tag, out_tag;

    mul_issue_ctrl #(.TAG_W(TAG_W)) dut (
        .mul_clk(mul_clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 mul_clk = ~mul_clk;

    typedef struct {
        logic             op;
        logic [31:0]      a, b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } vec_t;

    typedef struct {
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
        int               vis;
    } ent_t;

    vec_t  tbl [8];
    ent_t  mq [$];
    int    cyc = 0;
    int    nvec = 0;
    int    nerr = 0;
    logic  obs_rdy, obs_vld;
    logic [31:0] obs_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_half(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return op ? p[63:32] : p[31:0];
    endfunction

    // One clock cycle: drive at negedge, check settled outputs, advance the model at posedge.
    task automatic step(input logic v, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic ordy, input logic fl);
        logic e_vld, e_rdy, e_ofire, e_ifire;
        @(negedge mul_clk);
        in_valid = v; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
        out_ready = ordy; flush = fl;
        #1;
        e_vld   = (mq.size() > 0) && (mq[0].vis <= cyc);
        e_ofire = e_vld && ordy;
        e_rdy   = !fl && ((mq.size() - (e_ofire ? 1 : 0)) <= 1);
        e_ifire = v && e_rdy;
        chk("out_valid", 32'(out_valid), 32'(e_vld));
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        if (e_vld) begin
            chk("out_data", out_data, mq[0].d);
            chk("out_tag", 32'(out_tag), 32'(mq[0].t));
        end
        obs_rdy = in_ready; obs_vld = out_valid; obs_data = out_data;
        @(posedge mul_clk);
        cyc++;
        if (fl) mq.delete();
        else begin
            if (e_ofire) void'(mq.pop_front());
            if (e_ifire) mq.push_back('{d: ref_half(op, a, b), t: tag, vis: cyc + 1});
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 32'd0, 32'd0, '0, ordy, 1'b0);
    endtask

    // Issue one op into an empty controller and check the result two cycles later.
    task automatic issue_check(input vec_t t);
        step(1'b1, t.op, t.a, t.b, t.tag, 1'b0, 1'b0);
        chk("single_accept", 32'(obs_rdy), 32'd1);
        idle(1'b0);
        chk("latency_not_early", 32'(obs_vld), 32'd0);
        idle(1'b1);
        chk("latency_valid", 32'(obs_vld), 32'd1);
        chk("table_data", obs_data, t.exp);
    endtask

    initial begin
        int acc;
        tbl[0] = '{1'b0, 32'hFFFFFFFD, 32'h00000005, 5'd7,  32'hFFFFFFF1};
        tbl[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 5'd7,  32'hFFFFFFFF};
        tbl[2] = '{1'b1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000};
        tbl[3] = '{1'b0, 32'h80000000, 32'h80000000, 5'd2,  32'h00000000};
        tbl[4] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd3,  32'h3FFFFFFF};
        tbl[5] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd4,  32'h00000001};
        tbl[6] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'h00000000};
        tbl[7] = '{1'b0, 32'h00000006, 32'h00000007, 5'd9,  32'd42};

        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 1'b0;
        in_src1 = '0; in_src2 = '0; in_tag = '0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge mul_clk); @(negedge mul_clk);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) issue_check(tbl[i]);

        // Back-to-back: 8 requests with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i[0], 32'(i * 1000 - 3000), 32'(i + 11), 5'(i + 16), 1'b1, 1'b0);
            chk("b2b_in_ready", 32'(obs_rdy), 32'd1);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Backpressure: only two accepted while the consumer stalls.
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'(i + 2), 32'(i + 3), 5'(i + 20), 1'b0, 1'b0);
            if (obs_rdy) acc++;
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        idle(1'b1);
        chk("bp_ready_on_pop", 32'(obs_rdy), 32'd1);
        idle(1'b1);
        idle(1'b1);
        chk("bp_drained", 32'(obs_vld), 32'd0);

        // Flush after two requests, then a fresh request right after.
        step(1'b1, 1'b0, 32'd100, 32'd3, 5'd10, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hFFFF0000, 32'h00010000, 5'd11, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd5, 32'd5, 5'd12, 1'b0, 1'b1);
        chk("flush_in_ready", 32'(obs_rdy), 32'd0);
        step(1'b1, 1'b0, 32'd9, 32'hFFFFFFFE, 5'd13, 1'b0, 1'b0);
        chk("post_flush_empty", 32'(obs_vld), 32'd0);
        idle(1'b0);
        chk("post_flush_no_stale", 32'(obs_vld), 32'd0);
        idle(1'b1);
        chk("post_flush_data", obs_data, 32'hFFFFFFEE);

        // Asynchronous reset between edges with work buffered and in flight.
        step(1'b1, 1'b0, 32'd12, 32'd12, 5'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd13, 32'd13, 5'd2, 1'b0, 1'b0);
        @(negedge mul_clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_out_tag", 32'(out_tag), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        mq.delete();
        @(posedge mul_clk); cyc++;
        @(posedge mul_clk); cyc++;
        resetn = 1'b1;
        idle(1'b0);
        idle(1'b0);
        issue_check(tbl[7]);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
            if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h80000000;
            step($urandom_range(0, 3) != 0, 1'($urandom), a, b, 5'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
